// File: rtl/led_fade_sequencer_if.sv
// Control and level bundle between the LED fade sequencer
// and the exponential / sigma-delta output stage.
interface led_fade_sequencer_if;
    logic       enable;
    logic       next;
    logic [7:0] red_level;
    logic [7:0] green_level;
    logic [7:0] blue_level;
    logic       level_valid;
    logic [2:0] colour_index;
    logic       busy;

    modport master (
        output enable,
        output next,
        input  red_level,
        input  green_level,
        input  blue_level,
        input  level_valid,
        input  colour_index,
        input  busy
    );

    modport slave (
        input  enable,
        input  next,
        output red_level,
        output green_level,
        output blue_level,
        output level_valid,
        output colour_index,
        output busy
    );
endinterface

// File: rtl/led_fade_sequencer.sv
// Palette walker: ramps three log-domain levels toward each
// of eight fixed colours, dwelling HOLD_TICKS ticks on each.
module led_fade_sequencer #(
    parameter int PREDIV_BITS = 6,
    parameter int STEP        = 1,
    parameter int HOLD_TICKS  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    led_fade_sequencer_if.slave  bus
);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [8:0]    STEP9     = 9'(STEP);
    localparam logic [7:0]    STEP8     = 8'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_FADE, S_HOLD} state_t;

    state_t                 r_state, w_state;
    logic [PREDIV_BITS-1:0] r_pre;
    logic [HW-1:0]          r_hold, w_hold;
    logic                   r_pend, w_pend;
    logic [2:0]             r_idx, w_idx;
    logic [2:0][7:0]        r_lvl, w_lvl, w_tgt, w_stepped;
    logic                   r_valid, r_busy;
    logic                   w_tick;

    // Index 2 = red, 1 = green, 0 = blue.
    function automatic logic [23:0] f_pal(input logic [2:0] idx);
        case (idx)
            3'd0:    f_pal = 24'hFF0000;
            3'd1:    f_pal = 24'hFFFF00;
            3'd2:    f_pal = 24'h00FF00;
            3'd3:    f_pal = 24'h00FFFF;
            3'd4:    f_pal = 24'h0000FF;
            3'd5:    f_pal = 24'hFF00FF;
            3'd6:    f_pal = 24'hFFFFFF;
            default: f_pal = 24'h000000;
        endcase
    endfunction

    // Snap to target when within one step so levels never overshoot.
    function automatic logic [7:0] f_step(input logic [7:0] lvl,
                                          input logic [7:0] tgt);
        logic [8:0] d;
        d = {1'b0, tgt} - {1'b0, lvl};
        if (!d[8])
            f_step = (d <= STEP9) ? tgt : lvl + STEP8;
        else
            f_step = ((-d) <= STEP9) ? tgt : lvl - STEP8;
    endfunction

    assign w_tick = bus.enable && (&r_pre);
    assign w_tgt  = f_pal(r_idx);

    always_comb begin
        for (int c = 0; c < 3; c++)
            w_stepped[c] = f_step(r_lvl[c], w_tgt[c]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state;
    end

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_hold  = r_hold;
        w_pend  = r_pend;
        w_lvl   = r_lvl;
        unique case (r_state)
            S_IDLE: begin
                if (bus.enable) w_state = S_FADE;
            end
            S_FADE: begin
                if (!bus.enable) begin
                    w_state = S_IDLE;
                end else begin
                    if (bus.next) w_pend = 1'b1;
                    if (w_tick) begin
                        w_lvl = w_stepped;
                        if (w_stepped == w_tgt) begin
                            w_state = S_HOLD;
                            w_hold  = '0;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!bus.enable) begin
                    w_state = S_IDLE;
                end else if (r_pend || (w_tick && r_hold == HOLD_LAST)) begin
                    // A next pulse coinciding with expiry is absorbed here.
                    w_idx   = r_idx + 3'd1;
                    w_pend  = 1'b0;
                    w_state = S_FADE;
                end else begin
                    if (bus.next) w_pend = 1'b1;
                    if (w_tick)   w_hold = r_hold + HW'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre   <= '0;
            r_hold  <= '0;
            r_pend  <= 1'b0;
            r_idx   <= 3'd0;
            r_lvl   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (bus.enable) r_pre <= r_pre + PREDIV_BITS'(1);
            r_hold  <= w_hold;
            r_pend  <= w_pend;
            r_idx   <= w_idx;
            r_lvl   <= w_lvl;
            r_valid <= (w_lvl != r_lvl);
            r_busy  <= (w_state == S_FADE);
        end
    end

    assign bus.red_level    = r_lvl[2];
    assign bus.green_level  = r_lvl[1];
    assign bus.blue_level   = r_lvl[0];
    assign bus.level_valid  = r_valid;
    assign bus.colour_index = r_idx;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_led_fade_sequencer.sv
// Bench for led_fade_sequencer: level_valid pulses are scored
// against a queue of predicted palette ramps.
module tb_led_fade_sequencer;
    localparam int PB = 2;
    localparam int ST = 16;
    localparam int HT = 3;
    localparam logic [23:0] PAL [8] = '{
        24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF,
        24'h0000FF, 24'hFF00FF, 24'hFFFFFF, 24'h000000};

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [2:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    led_fade_sequencer_if bus();

    led_fade_sequencer #(
        .PREDIV_BITS(PB),
        .STEP       (ST),
        .HOLD_TICKS (HT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(negedge clk) begin
        if (!rst && bus.level_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: pulse r=%h g=%h b=%h idx=%0d, required no pulse",
                         bus.red_level, bus.green_level, bus.blue_level, bus.colour_index);
            end else begin
                mon_e = q.pop_front();
                if ({bus.red_level, bus.green_level, bus.blue_level, bus.colour_index} !== mon_e) begin
                    n_bad++;
                    $display("FAIL sb_level: got %h_%h_%h idx%0d required %h_%h_%h idx%0d",
                             bus.red_level, bus.green_level, bus.blue_level, bus.colour_index,
                             mon_e.r, mon_e.g, mon_e.b, mon_e.idx);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push_fade(input logic [23:0] from, input logic [2:0] idx);
        logic [23:0] to;
        int f[3], t[3], d[3], v[3];
        int n, mv;
        exp_t e;
        to = PAL[idx];
        n  = 0;
        for (int c = 0; c < 3; c++) begin
            f[c] = int'(from[8*c +: 8]);
            t[c] = int'(to[8*c +: 8]);
            d[c] = (t[c] > f[c]) ? t[c] - f[c] : f[c] - t[c];
            if ((d[c] + ST - 1) / ST > n) n = (d[c] + ST - 1) / ST;
        end
        for (int k = 1; k <= n; k++) begin
            for (int c = 0; c < 3; c++) begin
                mv   = (k * ST < d[c]) ? k * ST : d[c];
                v[c] = (t[c] >= f[c]) ? f[c] + mv : f[c] - mv;
            end
            e.r   = 8'(v[2]);
            e.g   = 8'(v[1]);
            e.b   = 8'(v[0]);
            e.idx = idx;
            q.push_back(e);
        end
    endtask

    task automatic test_reset();
        int nv;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.next = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        nv = 0;
        repeat (100) begin
            cyc();
            if (bus.level_valid) nv++;
        end
        n_cmp++;
        if (nv !== 0) begin n_bad++; $display("FAIL rst_valid: %0d pulses, required 0", nv); end
        n_cmp++;
        if ({bus.red_level, bus.green_level, bus.blue_level} !== 24'h0) begin
            n_bad++;
            $display("FAIL rst_levels: %h%h%h required 000000", bus.red_level, bus.green_level, bus.blue_level);
        end
        n_cmp++;
        if (bus.colour_index !== 3'd0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_idx_busy: idx=%0d busy=%b required 0/0", bus.colour_index, bus.busy);
        end
    endtask

    task automatic test_fade_up();
        int k;
        push_fade(24'h000000, 3'd0);
        bus.enable = 1'b1;
        k = 0;
        while (!bus.level_valid && k < 20) begin cyc(); k++; end
        n_cmp++;
        if (k !== 4 || bus.red_level !== 8'h10 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL first_tick: cycles=%0d red=%h busy=%b required 4/10/1", k, bus.red_level, bus.busy);
        end
        k = 0;
        while (bus.busy && k < 200) begin cyc(); k++; end
        n_cmp++;
        if (k !== 60) begin n_bad++; $display("FAIL fade0_len: %0d cycles required 60", k); end
        n_cmp++;
        if (q.size() !== 0 || {bus.red_level, bus.green_level, bus.blue_level} !== 24'hFF0000) begin
            n_bad++;
            $display("FAIL fade0_end: left=%0d levels=%h%h%h required 0/FF0000",
                     q.size(), bus.red_level, bus.green_level, bus.blue_level);
        end
    endtask

    task automatic test_next_in_hold();
        push_fade(PAL[0], 3'd1);
        bus.next = 1'b1;
        cyc();
        bus.next = 1'b0;
        n_cmp++;
        if (bus.colour_index !== 3'd0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL next_early: idx=%0d busy=%b required 0/0", bus.colour_index, bus.busy);
        end
        cyc();
        n_cmp++;
        if (bus.colour_index !== 3'd1 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL next_advance: idx=%0d busy=%b required 1/1", bus.colour_index, bus.busy);
        end
    endtask

    task automatic test_double_next();
        int k;
        push_fade(PAL[1], 3'd2);
        repeat (8) cyc();
        bus.next = 1'b1; cyc(); bus.next = 1'b0;
        repeat (5) cyc();
        bus.next = 1'b1; cyc(); bus.next = 1'b0;
        k = 0;
        while (bus.busy && k < 200) begin cyc(); k++; end
        n_cmp++;
        if (bus.busy !== 1'b0 || q.size() !== 16) begin
            n_bad++;
            $display("FAIL dbl_fade: busy=%b left=%0d required 0/16", bus.busy, q.size());
        end
        k = 0;
        while (bus.colour_index == 3'd1 && k < 50) begin cyc(); k++; end
        n_cmp++;
        if (k !== 1 || bus.colour_index !== 3'd2) begin
            n_bad++;
            $display("FAIL dbl_pending: cycles=%0d idx=%0d required 1/2", k, bus.colour_index);
        end
        k = 0;
        while (bus.busy && k < 200) begin cyc(); k++; end
        k = 0;
        while (bus.colour_index == 3'd2 && k < 50) begin cyc(); k++; end
        n_cmp++;
        if (k !== 12 || bus.colour_index !== 3'd3 || q.size() !== 0) begin
            n_bad++;
            $display("FAIL dbl_single: hold=%0d idx=%0d left=%0d required 12/3/0", k, bus.colour_index, q.size());
        end
    endtask

    task automatic test_wrap();
        logic [2:0] prev;
        int seen, k;
        push_fade(PAL[2], 3'd3);
        for (int i = 3; i < 8; i++) push_fade(PAL[i], 3'((i + 1) % 8));
        prev = 3'd3;
        seen = 0;
        k = 0;
        while (seen < 5 && k < 2000) begin
            cyc();
            k++;
            if (bus.colour_index != prev) begin
                n_cmp++;
                if (bus.colour_index !== prev + 3'd1) begin
                    n_bad++;
                    $display("FAIL wrap_seq: idx=%0d required %0d", bus.colour_index, prev + 3'd1);
                end
                prev = bus.colour_index;
                seen++;
            end
        end
        n_cmp++;
        if (seen !== 5 || {bus.red_level, bus.green_level, bus.blue_level} !== 24'h0 || q.size() !== 16) begin
            n_bad++;
            $display("FAIL wrap_zero: steps=%0d levels=%h%h%h left=%0d required 5/000000/16",
                     seen, bus.red_level, bus.green_level, bus.blue_level, q.size());
        end
        k = 0;
        while (bus.busy && k < 200) begin cyc(); k++; end
        n_cmp++;
        if (q.size() !== 0 || bus.red_level !== 8'hFF) begin
            n_bad++;
            $display("FAIL wrap_refade: left=%0d red=%h required 0/FF", q.size(), bus.red_level);
        end
    endtask

    task automatic test_enable_drop();
        int k, nv;
        push_fade(PAL[0], 3'd1);
        bus.enable = 1'b0;
        repeat (10) cyc();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.colour_index !== 3'd0 || bus.red_level !== 8'hFF) begin
            n_bad++;
            $display("FAIL dis_hold: busy=%b idx=%0d red=%h required 0/0/FF", bus.busy, bus.colour_index, bus.red_level);
        end
        bus.enable = 1'b1;
        cyc();
        k = 1;
        while (bus.busy && k < 20) begin cyc(); k++; end
        n_cmp++;
        if (k !== 4 || q.size() !== 16) begin
            n_bad++;
            $display("FAIL refade_match: cycles=%0d left=%0d required 4/16", k, q.size());
        end
        k = 0;
        while (bus.colour_index == 3'd0 && k < 50) begin cyc(); k++; end
        n_cmp++;
        if (k !== 12) begin n_bad++; $display("FAIL rehold_len: %0d cycles required 12", k); end
        k = 0;
        while (bus.green_level !== 8'h40 && k < 100) begin cyc(); k++; end
        bus.enable = 1'b0;
        nv = 0;
        repeat (20) begin
            cyc();
            if (bus.level_valid) nv++;
        end
        n_cmp++;
        if (nv !== 0 || bus.green_level !== 8'h40 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL freeze: pulses=%0d green=%h busy=%b required 0/40/0", nv, bus.green_level, bus.busy);
        end
        bus.enable = 1'b1;
        k = 0;
        cyc();
        while (bus.busy && k < 300) begin cyc(); k++; end
        n_cmp++;
        if (q.size() !== 0 || {bus.red_level, bus.green_level, bus.blue_level} !== 24'hFFFF00) begin
            n_bad++;
            $display("FAIL resume: left=%0d levels=%h%h%h required 0/FFFF00",
                     q.size(), bus.red_level, bus.green_level, bus.blue_level);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        rst = 1'b1;
        q.delete();
        cyc();
        rst = 1'b0;
        push_fade(24'h000000, 3'd0);
        k = 0;
        while (bus.red_level !== 8'h80 && k < 100) begin cyc(); k++; end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.red_level, bus.green_level, bus.blue_level} !== 24'h0 || bus.busy !== 1'b0 ||
            bus.level_valid !== 1'b0 || bus.colour_index !== 3'd0) begin
            n_bad++;
            $display("FAIL async_rst: levels=%h%h%h busy=%b valid=%b idx=%0d required 000000/0/0/0",
                     bus.red_level, bus.green_level, bus.blue_level, bus.busy, bus.level_valid, bus.colour_index);
        end
        q.delete();
        cyc();
        rst = 1'b0;
        push_fade(24'h000000, 3'd0);
        k = 0;
        while (!bus.level_valid && k < 20) begin cyc(); k++; end
        n_cmp++;
        if (k !== 4 || bus.red_level !== 8'h10) begin
            n_bad++;
            $display("FAIL rst_restart: cycles=%0d red=%h required 4/10", k, bus.red_level);
        end
    endtask

    initial begin
        test_reset();
        test_fade_up();
        test_next_in_hold();
        test_double_next();
        test_wrap();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
